// File: rtl/wb_fifo_sram_writer_if.sv
// Bundle of the writeback-FIFO handshakes: producer push port, base-address
// load, SRAM write port with request/grant, flush/done handshake, occupancy.
//
// Handshake rules:
//   push   : an entry transfers on a rising edge where push_valid && push_ready.
//            push_ready does not depend on push_valid.
//   sram   : sram_req is high while entries are buffered; a pop happens on an
//            edge where sram_req && sram_gnt, and the write shows up as a
//            one-cycle sram_wr_en strobe in the following cycle.
//   flush  : flush_req is a one-cycle pulse. flush_done is a one-cycle pulse
//            once every buffered entry has been written.
//
// dbg_state exposes the flush state machine encoding for checkers.

`ifndef FIFO_DEPTH
`define FIFO_DEPTH 32
`endif
`ifndef SRAM_ADDR_SIZE
`define SRAM_ADDR_SIZE 10
`endif
`ifndef SA_OUTPUT_WIDTH
`define SA_OUTPUT_WIDTH 13
`endif
`ifndef SA_WB_WIDTH
`define SA_WB_WIDTH 16
`endif

interface wb_fifo_sram_writer_if #(
  parameter int DEPTH  = `FIFO_DEPTH,
  parameter int ADDR_W = `SRAM_ADDR_SIZE,
  parameter int DATA_W = `SA_OUTPUT_WIDTH,
  parameter int WB_W   = `SA_WB_WIDTH
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                     push_valid;
  logic [ADDR_W+DATA_W-1:0] push_entry;
  logic                     push_ready;
  logic                     base_wr_en;
  logic [ADDR_W-1:0]        base_addr;
  logic                     sram_req;
  logic                     sram_gnt;
  logic                     sram_wr_en;
  logic [ADDR_W-1:0]        sram_wr_addr;
  logic [WB_W-1:0]          sram_wr_data;
  logic                     flush_req;
  logic                     flush_done;
  logic [CNT_W-1:0]         count;
  logic [1:0]               dbg_state;

  // The writer block itself.
  modport slave (
    input  push_valid, push_entry, base_wr_en, base_addr, sram_gnt, flush_req,
    output push_ready, sram_req, sram_wr_en, sram_wr_addr, sram_wr_data,
           flush_done, count, dbg_state
  );

  // Producer / controller / SRAM arbiter side.
  modport master (
    output push_valid, push_entry, base_wr_en, base_addr, sram_gnt, flush_req,
    input  push_ready, sram_req, sram_wr_en, sram_wr_addr, sram_wr_data,
           flush_done, count, dbg_state
  );
endinterface

// File: rtl/wb_fifo_sram_writer.sv
// Writeback FIFO drain into the output SRAM write port.
// Entries {addr, data} from the systolic-array writeback stage are buffered in
// a circular buffer and written out one per granted cycle at base + addr
// (wrapping), with the data widened to the SRAM word width.
// A flush pulse starts a drain; flush_done pulses once the buffer is empty and
// the last write strobe has retired.
//
// Optional build macro WB_RELU_EN: negative entry data is written as 0 and
// non-negative data is zero-extended. Without it data is sign-extended.

`ifndef FIFO_DEPTH
`define FIFO_DEPTH 32
`endif
`ifndef SRAM_ADDR_SIZE
`define SRAM_ADDR_SIZE 10
`endif
`ifndef SA_OUTPUT_WIDTH
`define SA_OUTPUT_WIDTH 13
`endif
`ifndef SA_WB_WIDTH
`define SA_WB_WIDTH 16
`endif

module wb_fifo_sram_writer #(
  parameter int DEPTH  = `FIFO_DEPTH,
  parameter int ADDR_W = `SRAM_ADDR_SIZE,
  parameter int DATA_W = `SA_OUTPUT_WIDTH,
  parameter int WB_W   = `SA_WB_WIDTH
) (
  input logic                    clock,
  input logic                    reset,
  wb_fifo_sram_writer_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Storage and bookkeeping
  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_base;

  // SRAM write port registers
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [WB_W-1:0]   r_wr_data;

  // Flush state machine
  state_t r_state;
  state_t w_state_nxt;
  logic   w_flush_done;

  logic              w_push_ready;
  logic              w_sram_req;
  logic              w_push;
  logic              w_pop;
  logic [ENT_W-1:0]  w_head;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [ADDR_W-1:0] w_wr_addr_nxt;
  logic [WB_W-1:0]   w_wr_data_nxt;

  // Both flags come straight from the registered count, so a push into an
  // empty buffer cannot be popped in the same cycle and a full buffer never
  // takes a push even if a pop happens that cycle.
  assign w_push_ready = (r_count != FULL_CNT);
  assign w_sram_req   = (r_count != '0);
  assign w_push       = bus.push_valid && w_push_ready;
  assign w_pop        = w_sram_req && bus.sram_gnt;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_addr = w_head[ENT_W-1:DATA_W];
  assign w_head_data = w_head[DATA_W-1:0];

  // Address offset wraps inside the SRAM address space (carry dropped).
  assign w_wr_addr_nxt = r_base + w_head_addr;

`ifdef WB_RELU_EN
  assign w_wr_data_nxt = w_head_data[DATA_W-1] ? '0
                       : {{(WB_W-DATA_W){1'b0}}, w_head_data};
`else
  assign w_wr_data_nxt = {{(WB_W-DATA_W){w_head_data[DATA_W-1]}}, w_head_data};
`endif

  // Entry storage; contents need no reset since the count gates every read.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.push_entry;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Base output address; a pop on the same edge still sees the old value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_base <= '0;
    end else if (bus.base_wr_en) begin
      r_base <= bus.base_addr;
    end
  end

  // Registered SRAM write port: strobe for one cycle per pop, addr/data hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_pop;
      if (w_pop) begin
        r_wr_addr <= w_wr_addr_nxt;
        r_wr_data <= w_wr_data_nxt;
      end
    end
  end

  // Flush state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush next-state and done pulse. The drain is complete only once the
  // buffer is empty and the final write strobe has left the port.
  always_comb begin
    w_state_nxt  = r_state;
    w_flush_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.flush_req) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if ((r_count == '0) && !r_wr_en) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_flush_done = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.push_ready   = w_push_ready;
  assign bus.sram_req     = w_sram_req;
  assign bus.sram_wr_en   = r_wr_en;
  assign bus.sram_wr_addr = r_wr_addr;
  assign bus.sram_wr_data = r_wr_data;
  assign bus.flush_done   = w_flush_done;
  assign bus.count        = r_count;
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_wb_fifo_sram_writer.sv
// Bench for wb_fifo_sram_writer: directed scenarios plus a randomized phase,
// checked every cycle against a queue-based model of the writer.

module tb_wb_fifo_sram_writer;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 13;
  localparam int WB_W   = 16;

`ifdef WB_RELU_EN
  localparam logic [15:0] T2_DATA = 16'h0000;
`else
  localparam logic [15:0] T2_DATA = 16'hFFFF;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  wb_fifo_sram_writer_if #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_W(WB_W)
  ) bus ();

  wb_fifo_sram_writer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_W(WB_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- counters ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit cmp_en = 1'b0;

  // ---------------- model state ----------------
  logic [22:0] m_q[$];        // buffered entries {addr, data}
  logic [25:0] exp_q[$];      // scoreboard: expected writes {addr, data}
  int          m_base;
  logic        m_wr_en;
  int          m_addr;
  int          m_data;
  bit          m_flushing;
  bit          m_done;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Value written to SRAM for a 13-bit two's-complement datum.
  function automatic int wb_value(input logic [12:0] d);
    int v;
    v = int'(d);
    if (v >= 4096) v = v - 8192;
`ifdef WB_RELU_EN
    if (v < 0) v = 0;
`endif
    return v & 32'hFFFF;
  endfunction

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_base     = 0;
    m_wr_en    = 1'b0;
    m_addr     = 0;
    m_data     = 0;
    m_flushing = 1'b0;
    m_done     = 1'b0;
  endtask

  // One rising edge of the model, using the inputs presented in the cycle.
  task automatic model_edge();
    int          sz;
    logic        was_wr;
    logic [22:0] e;
    bit          pop;
    bit          push;
    if (reset) begin
      model_reset();
      return;
    end
    sz     = m_q.size();
    was_wr = m_wr_en;
    pop    = (sz != 0) && bus.sram_gnt;
    push   = bus.push_valid && (sz < DEPTH);
    if (pop) begin
      e       = m_q.pop_front();
      m_wr_en = 1'b1;
      m_addr  = (m_base + int'(e[22:13])) % 1024;
      m_data  = wb_value(e[12:0]);
      exp_q.push_back({m_addr[9:0], m_data[15:0]});
    end else begin
      m_wr_en = 1'b0;
    end
    if (push) m_q.push_back(bus.push_entry);
    if (bus.base_wr_en) m_base = int'(bus.base_addr);
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_flushing) begin
      if (sz == 0 && !was_wr) begin
        m_flushing = 1'b0;
        m_done     = 1'b1;
      end
    end else if (bus.flush_req) begin
      m_flushing = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    bus.push_valid = 1'b0;
    bus.push_entry = '0;
    bus.base_wr_en = 1'b0;
    bus.base_addr  = '0;
    bus.sram_gnt   = 1'b0;
    bus.flush_req  = 1'b0;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.push_valid = 1'b1;
      bus.push_entry = 23'($urandom);
      tick();
    end
    bus.push_valid = 1'b0;
  endtask

  // ---------------- compare process / scoreboard ----------------
  always @(negedge clock) begin
    logic [25:0] e;
    if (cmp_en) begin
      check("push_ready", 32'(bus.push_ready), 32'(m_q.size() < DEPTH));
      check("sram_req",   32'(bus.sram_req),   32'(m_q.size() != 0));
      check("count",      32'(bus.count),      32'(m_q.size()));
      check("wr_en",      32'(bus.sram_wr_en), 32'(m_wr_en));
      check("wr_addr",    32'(bus.sram_wr_addr), 32'(m_addr));
      check("wr_data",    32'(bus.sram_wr_data), 32'(m_data));
      check("flush_done", 32'(bus.flush_done), 32'(m_done));
      if (bus.sram_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL order: write %0h/%0h, expected no write (cycle %0d)",
                   bus.sram_wr_addr, bus.sram_wr_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("order", 32'({bus.sram_wr_addr, bus.sram_wr_data}), 32'(e));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: run still active at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int writes, first_wr, last_wr, pulses, done_cyc, seen_wr, seen_done;
    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (3) tick();
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Reset state
    check("rst_push_ready", 32'(bus.push_ready), 32'd1);
    check("rst_count",      32'(bus.count),      32'd0);
    check("rst_sram_req",   32'(bus.sram_req),   32'd0);
    check("rst_wr_en",      32'(bus.sram_wr_en), 32'd0);
    check("rst_flush_done", 32'(bus.flush_done), 32'd0);

    // T1: single entry latency, base 0
    bus.sram_gnt   = 1'b1;
    bus.push_valid = 1'b1;
    bus.push_entry = {10'd5, 13'h0007};
    tick();
    bus.push_valid = 1'b0;
    check("t1_n1_wr_en", 32'(bus.sram_wr_en), 32'd0);
    check("t1_n1_count", 32'(bus.count), 32'd1);
    tick();
    check("t1_wr_en",  32'(bus.sram_wr_en),   32'd1);
    check("t1_addr",   32'(bus.sram_wr_addr), 32'd5);
    check("t1_data",   32'(bus.sram_wr_data), 32'h0007);
    check("t1_count",  32'(bus.count),        32'd0);

    // T2: address wrap and negative data
    bus.base_wr_en = 1'b1;
    bus.base_addr  = 10'd1020;
    tick();
    bus.base_wr_en = 1'b0;
    bus.push_valid = 1'b1;
    bus.push_entry = {10'd10, 13'h1FFF};
    tick();
    bus.push_valid = 1'b0;
    tick();
    check("t2_wr_en", 32'(bus.sram_wr_en),   32'd1);
    check("t2_addr",  32'(bus.sram_wr_addr), 32'd6);
    check("t2_data",  32'(bus.sram_wr_data), 32'(T2_DATA));

    // T3: fill to full with no grant, then drain back-to-back
    bus.sram_gnt = 1'b0;
    push_n(33);
    check("t3_push_ready_full", 32'(bus.push_ready), 32'd0);
    check("t3_count_full",      32'(bus.count),      32'd32);
    bus.sram_gnt = 1'b1;
    writes = 0; first_wr = -1; last_wr = -1;
    for (int i = 0; i < 36; i++) begin
      tick();
      if (bus.sram_wr_en === 1'b1) begin
        writes++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
    end
    check("t3_writes",      32'(writes), 32'd32);
    check("t3_consecutive", 32'(last_wr - first_wr), 32'd31);

    // T4: flush with 4 entries while grant toggles
    bus.sram_gnt = 1'b0;
    push_n(4);
    pulses = 0; done_cyc = -1; last_wr = -1;
    for (int i = 0; i < 40; i++) begin
      bus.flush_req = (i == 0);
      bus.sram_gnt  = (i % 2 == 0);
      tick();
      if (bus.sram_wr_en === 1'b1) last_wr = cyc;
      if (bus.flush_done === 1'b1) begin
        pulses++;
        done_cyc = cyc;
      end
    end
    bus.flush_req = 1'b0;
    bus.sram_gnt  = 1'b0;
    check("t4_pulses", 32'(pulses), 32'd1);
    check("t4_done_after_last_wr", 32'(done_cyc > last_wr), 32'd1);

    // Empty flush: done in the second cycle after the pulse
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    check("ef_p1_done", 32'(bus.flush_done), 32'd0);
    tick();
    check("ef_p2_done", 32'(bus.flush_done), 32'd1);
    tick();
    check("ef_p3_done", 32'(bus.flush_done), 32'd0);

    // T5: base change on the same edge as a pop
    bus.base_wr_en = 1'b1;
    bus.base_addr  = 10'd0;
    tick();
    bus.base_wr_en = 1'b0;
    bus.push_valid = 1'b1;
    bus.push_entry = {10'd3, 13'h0011};
    tick();
    bus.push_entry = {10'd3, 13'h0022};
    tick();
    bus.push_valid = 1'b0;
    bus.sram_gnt   = 1'b1;
    bus.base_wr_en = 1'b1;
    bus.base_addr  = 10'd100;
    tick();
    bus.base_wr_en = 1'b0;
    check("t5_old_base_addr", 32'(bus.sram_wr_addr), 32'd3);
    check("t5_old_base_data", 32'(bus.sram_wr_data), 32'h0011);
    tick();
    check("t5_new_base_addr", 32'(bus.sram_wr_addr), 32'd103);
    check("t5_new_base_data", 32'(bus.sram_wr_data), 32'h0022);
    bus.sram_gnt = 1'b0;

    // T6: reset in the middle of a flush with 8 entries
    push_n(8);
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_wr_en",       32'(bus.sram_wr_en),   32'd0);
    check("t6_addr",        32'(bus.sram_wr_addr), 32'd0);
    check("t6_data",        32'(bus.sram_wr_data), 32'd0);
    check("t6_flush_done",  32'(bus.flush_done),   32'd0);
    check("t6_count",       32'(bus.count),        32'd0);
    check("t6_push_ready",  32'(bus.push_ready),   32'd1);
    check("t6_sram_req",    32'(bus.sram_req),     32'd0);
    tick();
    reset = 1'b0;
    bus.sram_gnt = 1'b1;
    seen_wr = 0; seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.sram_wr_en === 1'b1) seen_wr++;
      if (bus.flush_done === 1'b1) seen_done++;
    end
    check("t6_no_write_after", 32'(seen_wr),   32'd0);
    check("t6_no_done_after",  32'(seen_done), 32'd0);

    // Randomized phase: low-grant half builds backlog, high-grant half drains
    for (int i = 0; i < 2000; i++) begin
      bus.push_valid = ($urandom_range(0, 99) < 60);
      bus.push_entry = 23'($urandom);
      bus.sram_gnt   = (i < 1000) ? ($urandom_range(0, 99) < 35)
                                  : ($urandom_range(0, 99) < 80);
      bus.base_wr_en = ($urandom_range(0, 99) < 3);
      bus.base_addr  = 10'($urandom);
      bus.flush_req  = ($urandom_range(0, 99) < 2);
      tick();
    end
    idle_inputs();
    bus.sram_gnt = 1'b1;
    repeat (40) tick();
    check("final_count", 32'(bus.count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
